cond_unit: RTL and testbench

Conditional-execution unit of the single-cycle ARM datapath, directly downstream of `alu`. It captures `ALUFlags` into the architectural NZCV register under `FlagW` control and evaluates the instruction's 4-bit condition field against the stored flags. It gates the decoder's write and branch enables so that failed-condition instructions have no architectural effect. It also keeps saturating executed/skipped instruction counters for debug.

---
 rtl/arm_pkg.sv | 32 +++
 rtl/cond_check.sv | 48 ++++
 rtl/cond_unit.sv | 92 +++++++++
 tb/tb_cond_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM datapath: condition mnemonics and NZCV bit positions.
// Pure declarations; no logic, no latency.
// No flow control involved.
package arm_pkg;

    // Instruction condition field, bits [31:28]
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,  // Z
        COND_NE = 4'b0001,  // !Z
        COND_CS = 4'b0010,  // C
        COND_CC = 4'b0011,  // !C
        COND_MI = 4'b0100,  // N
        COND_PL = 4'b0101,  // !N
        COND_VS = 4'b0110,  // V
        COND_VC = 4'b0111,  // !V
        COND_HI = 4'b1000,  // C & !Z
        COND_LS = 4'b1001,  // !C | Z
        COND_GE = 4'b1010,  // N == V
        COND_LT = 4'b1011,  // N != V
        COND_GT = 4'b1100,  // !Z & (N == V)
        COND_LE = 4'b1101,  // Z | (N != V)
        COND_AL = 4'b1110,  // always
        COND_NV = 4'b1111   // treated as always, no trap
    } cond_e;

    // Bit positions inside the 4-bit {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Condition evaluator: decides whether an instruction's Cond field passes against NZCV.
// Purely combinational, zero latency.
// No backpressure; output follows inputs every cycle.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = i_flags[FLAG_N];
    assign w_z  = i_flags[FLAG_Z];
    assign w_c  = i_flags[FLAG_C];
    assign w_v  = i_flags[FLAG_V];
    // Signed greater-or-equal is shared by GE/LT/GT/LE
    assign w_ge = (w_n == w_v);

    // Map each condition mnemonic onto its flag expression
    always_comb begin
        o_cond_ex = 1'b1;
        case (cond_e'(i_cond))
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = w_ge;
            COND_LT: o_cond_ex = ~w_ge;
            COND_GT: o_cond_ex = ~w_z & w_ge;
            COND_LE: o_cond_ex = w_z | ~w_ge;
            // AL and the unused 1111 encoding both execute unconditionally
            default: o_cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV register, enable gating, saturating exec/skip counters.
// Enables are combinational from Cond/Flags/Valid; flags and counters update one edge later.
// No backpressure; a failed condition squashes writes, branch and flag updates.
module cond_unit
    import arm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             CntClr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_skip_cnt;
    logic             w_cond_ex;
    logic             w_ok;

    // Condition is judged on the stored flags only, so ALUFlags never reaches an output
    cond_check u_cond_check (
        .i_cond    (Cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    assign w_ok = w_cond_ex & Valid;

    assign CondEx    = w_cond_ex;
    assign PCSrc     = PCS & w_ok;
    // Compare/test instructions set flags but never write a destination register
    assign RegWrite  = RegW & w_ok & ~NoWrite;
    assign MemWrite  = MemW & w_ok;
    assign Flags     = r_flags;
    assign ExecCount = r_exec_cnt;
    assign SkipCount = r_skip_cnt;

    // NZCV register: N,Z and C,V halves load independently, only for instructions that execute
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (FlagW[1] && w_ok) begin
                r_flags[FLAG_N] <= ALUFlags[FLAG_N];
                r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0] && w_ok) begin
                r_flags[FLAG_C] <= ALUFlags[FLAG_C];
                r_flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Debug counters: clear wins over increment, and both stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (CntClr) begin
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (Valid) begin
            if (w_cond_ex) begin
                if (r_exec_cnt != CNT_MAX) begin
                    r_exec_cnt <= r_exec_cnt + CNT_W'(1);
                end
            end else begin
                if (r_skip_cnt != CNT_MAX) begin
                    r_skip_cnt <= r_skip_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit with 4-bit counters so saturation is reachable quickly.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Each scenario task carries its own inline comparisons.
module tb_cond_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             Valid;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             CntClr;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SkipCount;

    int total = 0;
    int bad   = 0;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Valid     (Valid),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NoWrite   (NoWrite),
        .CntClr    (CntClr),
        .PCSrc     (PCSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .CondEx    (CondEx),
        .Flags     (Flags),
        .ExecCount (ExecCount),
        .SkipCount (SkipCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table written straight from the mnemonic definitions
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Valid = 0; Cond = 4'b1110; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; CntClr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
        total++; if (ExecCount !== 4'd0) begin bad++; $display("FAIL reset_exec got=%0d exp=0", ExecCount); end
        total++; if (SkipCount !== 4'd0) begin bad++; $display("FAIL reset_skip got=%0d exp=0", SkipCount); end
        reset = 0;
        Valid = 1; Cond = 4'b0000; PCS = 1;
        #1;
        total++; if (CondEx !== 1'b0) begin bad++; $display("FAIL reset_eq_condex got=%b exp=0", CondEx); end
        total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL reset_eq_pcsrc got=%b exp=0", PCSrc); end
        Cond = 4'b1110; PCS = 0; RegW = 1;
        #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL reset_al_regwrite got=%b exp=1", RegWrite); end
        total++; if (CondEx !== 1'b1) begin bad++; $display("FAIL reset_al_condex got=%b exp=1", CondEx); end
        Valid = 0; RegW = 0;
        tick();
    endtask

    task automatic test_subs();
        Valid = 1; Cond = 4'b1110; ALUFlags = 4'b0100; FlagW = 2'b11;
        #1;
        // Same cycle: flags not yet updated, so EQ would still fail
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL subs_same_cycle got=%b exp=0000", Flags); end
        tick();
        FlagW = 0; ALUFlags = 4'b1011;
        #1;
        total++; if (Flags !== 4'b0100) begin bad++; $display("FAIL subs_flags got=%b exp=0100", Flags); end
        Cond = 4'b0000; MemW = 1;
        #1;
        total++; if (MemWrite !== 1'b1) begin bad++; $display("FAIL subs_eq_memwrite got=%b exp=1", MemWrite); end
        Cond = 4'b0001;
        #1;
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL subs_ne_memwrite got=%b exp=0", MemWrite); end
        MemW = 0; Valid = 0;
        tick();
        total++; if (Flags !== 4'b0100) begin bad++; $display("FAIL subs_hold got=%b exp=0100", Flags); end
    endtask

    task automatic test_partial();
        Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        total++; if (Flags !== 4'b1111) begin bad++; $display("FAIL partial_load got=%b exp=1111", Flags); end
        FlagW = 2'b10; ALUFlags = 4'b0000;
        tick();
        total++; if (Flags !== 4'b0011) begin bad++; $display("FAIL partial_nz got=%b exp=0011", Flags); end
        FlagW = 2'b01; ALUFlags = 4'b0000;
        tick();
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL partial_cv got=%b exp=0000", Flags); end
        Valid = 0; FlagW = 0;
    endtask

    task automatic test_failed_cond();
        Valid = 0; CntClr = 1;
        tick();
        CntClr = 0;
        total++; if (ExecCount !== 4'd0 || SkipCount !== 4'd0) begin bad++; $display("FAIL fail_clear got=%0d/%0d exp=0/0", ExecCount, SkipCount); end
        Valid = 1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1010; RegW = 1;
        #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL fail_regwrite got=%b exp=0", RegWrite); end
        tick();
        Valid = 0; RegW = 0; FlagW = 0;
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL fail_flags got=%b exp=0000", Flags); end
        total++; if (SkipCount !== 4'd1) begin bad++; $display("FAIL fail_skip got=%0d exp=1", SkipCount); end
        total++; if (ExecCount !== 4'd0) begin bad++; $display("FAIL fail_exec got=%0d exp=0", ExecCount); end
    endtask

    task automatic test_sweep();
        for (int f = 0; f < 16; f++) begin
            Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'(f);
            tick();
            Valid = 0; FlagW = 0; PCS = 1;
            total++; if (Flags !== 4'(f)) begin bad++; $display("FAIL sweep_load got=%b exp=%b", Flags, 4'(f)); end
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                #1;
                total++; if (CondEx !== ref_cond(4'(c), 4'(f))) begin bad++; $display("FAIL sweep_cond f=%b c=%b got=%b exp=%b", 4'(f), 4'(c), CondEx, ref_cond(4'(c), 4'(f))); end
                total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL sweep_invalid_pcsrc f=%b c=%b got=%b exp=0", 4'(f), 4'(c), PCSrc); end
            end
            PCS = 0;
        end
    endtask

    task automatic test_signed();
        Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1001;
        tick();
        Valid = 0; FlagW = 0;
        Cond = 4'b1010; #1;
        total++; if (CondEx !== 1'b1) begin bad++; $display("FAIL signed_ge_1001 got=%b exp=1", CondEx); end
        Cond = 4'b1011; #1;
        total++; if (CondEx !== 1'b0) begin bad++; $display("FAIL signed_lt_1001 got=%b exp=0", CondEx); end
        Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1000;
        tick();
        Valid = 0; FlagW = 0;
        Cond = 4'b1100; #1;
        total++; if (CondEx !== 1'b0) begin bad++; $display("FAIL signed_gt_1000 got=%b exp=0", CondEx); end
        Cond = 4'b1101; #1;
        total++; if (CondEx !== 1'b1) begin bad++; $display("FAIL signed_le_1000 got=%b exp=1", CondEx); end
        // CMP: flags update, destination write suppressed
        Valid = 1; Cond = 4'b1110; NoWrite = 1; RegW = 1; FlagW = 2'b11; ALUFlags = 4'b0110;
        #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL cmp_regwrite got=%b exp=0", RegWrite); end
        tick();
        Valid = 0; NoWrite = 0; RegW = 0; FlagW = 0;
        total++; if (Flags !== 4'b0110) begin bad++; $display("FAIL cmp_flags got=%b exp=0110", Flags); end
    endtask

    task automatic test_counters();
        Valid = 0; CntClr = 1;
        tick();
        CntClr = 0;
        Valid = 1; Cond = 4'b1110;
        for (int i = 0; i < 15; i++) tick();
        total++; if (ExecCount !== 4'd15) begin bad++; $display("FAIL cnt_exec_15 got=%0d exp=15", ExecCount); end
        for (int i = 0; i < 5; i++) tick();
        total++; if (ExecCount !== 4'd15) begin bad++; $display("FAIL cnt_exec_sat got=%0d exp=15", ExecCount); end
        total++; if (SkipCount !== 4'd0) begin bad++; $display("FAIL cnt_skip_zero got=%0d exp=0", SkipCount); end
        // Flags are 0110 (Z=1), so NE fails
        Cond = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        total++; if (SkipCount !== 4'd3) begin bad++; $display("FAIL cnt_skip_3 got=%0d exp=3", SkipCount); end
        Valid = 0; Cond = 4'b1110;
        for (int i = 0; i < 3; i++) tick();
        total++; if (ExecCount !== 4'd15 || SkipCount !== 4'd3) begin bad++; $display("FAIL cnt_invalid_hold got=%0d/%0d exp=15/3", ExecCount, SkipCount); end
        Valid = 1; CntClr = 1;
        tick();
        total++; if (ExecCount !== 4'd0 || SkipCount !== 4'd0) begin bad++; $display("FAIL cnt_clr_priority got=%0d/%0d exp=0/0", ExecCount, SkipCount); end
        CntClr = 0;
        tick();
        total++; if (ExecCount !== 4'd1) begin bad++; $display("FAIL cnt_after_clr got=%0d exp=1", ExecCount); end
        Valid = 0;
    endtask

    task automatic test_reset_mid();
        Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        total++; if (Flags !== 4'b1111 || ExecCount !== 4'd2) begin bad++; $display("FAIL mid_pre got=%b/%0d exp=1111/2", Flags, ExecCount); end
        CntClr = 1;
        reset = 1;
        #1;
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL mid_async_flags got=%b exp=0000", Flags); end
        total++; if (ExecCount !== 4'd0) begin bad++; $display("FAIL mid_async_exec got=%0d exp=0", ExecCount); end
        tick();
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL mid_held_flags got=%b exp=0000", Flags); end
        idle_inputs();
        reset = 0;
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_subs();
        test_partial();
        test_failed_cond();
        test_sweep();
        test_signed();
        test_counters();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
